ping_pong_line_buffer: RTL and testbench
========================================

# ping_pong_line_buffer

Double-buffered line store between the frame-fetch side and the HUB-75 row driver. The writer fills a back bank while the driver scans a stable front bank; a committed line becomes visible only at the driver's line boundary, so no tearing. It generalises the single-bank line buffer with these features:
- a configurable line length;
- a registered read with a valid flag;
- a commit/release bank-swap handshake;
- write-side back-pressure and error reporting.

## Interface
Parameters:
- address_width, 6, address bits per bank; each bank holds 1<<address_width words
- data_width, 24, bits per pixel word (e.g. 3×8-bit RGB)
- line_length, 64, valid words per line; must satisfy 1 ≤ line_length ≤ 1<<address_width

Ports:
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- write_address  in  address_width  back-bank word address
- write_data  in  data_width  word to store
- write_enable  in  1  store write_data at write_address this cycle
- write_commit  in  1  back bank complete; request swap
- write_ready  out  1  back bank accepts writes/commit
- write_error  out  1  sticky: a write or commit was dropped
- read_address  in  address_width  front-bank word address
- read_enable  in  1  read request
- read_data  out  data_width  registered read result
- read_valid  out  1  read_data holds a valid front-bank word
- read_release  in  1  driver finished scanning the current front line
- front_valid  out  1  front bank holds a committed line

## Operation
- State registers:
  - front_sel: index of the front bank; the back bank is !front_sel.
  - pending: back bank committed, swap not yet taken.
  - front_valid.
  - write_error.
- Write path:
  - write_ready = !pending, combinational from the register.
  - A write is accepted when write_enable && write_ready && write_address < line_length.
  - An accepted write stores into the back bank.
  - write_enable while write_ready=0, or with write_address ≥ line_length, stores nothing and sets write_error.
- Commit:
  - Accepted when write_commit && write_ready.
  - If front_valid=0, swap at this edge: front_sel toggles, front_valid←1, pending stays 0.
  - Otherwise pending←1.
  - write_commit while write_ready=0 is ignored and sets write_error.
- Release:
  - read_release with pending=1 (registered value) swaps: front_sel toggles, pending←0, front_valid stays 1.
  - read_release with pending=0 changes nothing; the front line is retained and rescanned.
- Reads:
  - read_enable samples front bank[read_address] using the pre-edge front_sel.
  - If front_valid=0 or read_address ≥ line_length: read_data←0, read_valid←0.
- Bank contents are not cleared by reset. Reads are gated by front_valid, so stale data is never presented as valid.
- write_error clears only on reset.

## Timing
- Reset (reset=0 at an edge) sets:
  - front_sel=0, pending=0, front_valid=0, write_error=0
  - read_data=0, read_valid=0
  - write_ready=1 (derived)
- Reset mid-operation abandons any pending line and the front line. The first commit after reset swaps immediately.
- Read latency is 1 cycle: request at edge N gives read_data/read_valid after edge N. They hold until the next edge. read_enable=0 gives read_valid←0 with read_data unchanged.
- Write and commit in the same cycle: the write lands before the swap, so the word belongs to the committed line.
- Commit and release in the same cycle with pending=0 and front_valid=1: pending←1, no swap. The swap occurs at the next release.
- Read and swap in the same cycle: the read returns the old front bank. Reads from the next cycle on see the new bank.
- Write after a swap targets the new back bank, i.e. the previous front.
- After commit, write_ready falls the next cycle. After a swap-by-release, write_ready rises the next cycle.
- Throughput: one write and one read per cycle, with no mutual stall.

## Test plan
- Reset, then read address 0 with read_enable=1 -> read_valid=0, read_data=0, front_valid=0, write_ready=1.
- Write words 0..63 = 0x000100+i, commit -> next cycle front_valid=1, write_ready=1; read address 5 -> after 1 cycle read_data=0x000105, read_valid=1.
- With front valid:
  - write 0xAAAAAA to all 64 addresses, commit -> write_ready=0;
  - reads still return 0x0001xx;
  - read_release -> next-cycle reads return 0xAAAAAA, write_ready=1.
- While pending:
  - write_enable to address 3 -> write_error=1, back line unchanged after swap;
  - write to address 64 with line_length=64 -> dropped, write_error=1.
- Same-cycle read of address 7 and read_release with pending -> returns the old word; the next read of address 7 returns the new word.
- Same-cycle write_commit and read_release with pending=0, front_valid=1 -> no swap; a second release swaps. Assert reset mid-pending -> all outputs at reset values.

Source files
------------

// File: rtl/ping_pong_line_buffer_if.sv
// Writer and row-driver signals of the ping-pong line buffer.
// The master side is the frame-fetch writer and the HUB-75 driver. The slave side is the buffer.
interface ping_pong_line_buffer_if #(
  parameter int address_width = 6,
  parameter int data_width    = 24
);
  logic [address_width-1:0] write_address;
  logic [data_width-1:0]    write_data;
  logic                     write_enable;
  logic                     write_commit;
  logic                     write_ready;
  logic                     write_error;
  logic [address_width-1:0] read_address;
  logic                     read_enable;
  logic [data_width-1:0]    read_data;
  logic                     read_valid;
  logic                     read_release;
  logic                     front_valid;

  modport master (
    output write_address, write_data, write_enable, write_commit,
    output read_address, read_enable, read_release,
    input  write_ready, write_error, read_data, read_valid, front_valid
  );

  modport slave (
    input  write_address, write_data, write_enable, write_commit,
    input  read_address, read_enable, read_release,
    output write_ready, write_error, read_data, read_valid, front_valid
  );
endinterface

// File: rtl/ping_pong_line_buffer.sv
// Double-buffered line store. The writer fills the back bank while the driver scans the front bank.
// A committed line becomes the front line only at a driver release, or at once if no front line exists.
module ping_pong_line_buffer #(
  parameter int address_width = 6,
  parameter int data_width    = 24,
  parameter int line_length   = 64
) (
  input logic                    clock,
  input logic                    reset,
  ping_pong_line_buffer_if.slave bus
);
  localparam int depth = 1 << address_width;
  localparam logic [address_width:0] line_len = (address_width + 1)'(line_length);

  // Both banks share one array. The bank index is the top address bit.
  logic [data_width-1:0] mem_q [2*depth];

  logic front_sel_q, front_sel_d;
  logic pending_q, pending_d;
  logic front_valid_q, front_valid_d;
  logic write_error_q, write_error_d;
  logic [data_width-1:0] read_data_q;
  logic read_valid_q;

  logic write_in_range, read_in_range;
  logic write_accept, commit_accept, release_swap, read_hit;

  always_comb begin
    write_in_range = {1'b0, bus.write_address} < line_len;
    read_in_range  = {1'b0, bus.read_address} < line_len;
    write_accept   = bus.write_enable && !pending_q && write_in_range;
    commit_accept  = bus.write_commit && !pending_q;
    release_swap   = bus.read_release && pending_q;
    read_hit       = bus.read_enable && front_valid_q && read_in_range;
  end

  // A commit needs pending=0 and a release swap needs pending=1, so the two never coincide.
  always_comb begin
    front_sel_d   = front_sel_q;
    pending_d     = pending_q;
    front_valid_d = front_valid_q;
    write_error_d = write_error_q;
    if (commit_accept) begin
      if (!front_valid_q) begin
        front_sel_d   = !front_sel_q;
        front_valid_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else if (release_swap) begin
      front_sel_d = !front_sel_q;
      pending_d   = 1'b0;
    end
    if (bus.write_enable && !write_accept) write_error_d = 1'b1;
    if (bus.write_commit && pending_q) write_error_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      front_sel_q   <= 1'b0;
      pending_q     <= 1'b0;
      front_valid_q <= 1'b0;
      write_error_q <= 1'b0;
    end else begin
      front_sel_q   <= front_sel_d;
      pending_q     <= pending_d;
      front_valid_q <= front_valid_d;
      write_error_q <= write_error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (write_accept) mem_q[{!front_sel_q, bus.write_address}] <= bus.write_data;
  end

  // The read uses the front select from before the edge, so a read that coincides with a swap returns the old line.
  always_ff @(posedge clock) begin
    if (!reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else if (bus.read_enable) begin
      if (read_hit) begin
        read_data_q  <= mem_q[{front_sel_q, bus.read_address}];
        read_valid_q <= 1'b1;
      end else begin
        read_data_q  <= '0;
        read_valid_q <= 1'b0;
      end
    end else begin
      read_valid_q <= 1'b0;
    end
  end

  assign bus.write_ready = !pending_q;
  assign bus.write_error = write_error_q;
  assign bus.read_data   = read_data_q;
  assign bus.read_valid  = read_valid_q;
  assign bus.front_valid = front_valid_q;
endmodule

// File: tb/tb_ping_pong_line_buffer.sv
// Directed bench for ping_pong_line_buffer. The address width is 7, which leaves room for an out-of-range address 64.
// Fill and scan loops run by hand. Table vectors cover the handshake corner cases.
module tb_ping_pong_line_buffer;
  localparam int AW = 7;
  localparam int DW = 24;
  localparam int LL = 64;

  typedef struct {
    int rst_n, we, wa, wd, wc, re, ra, rel;
    int rd, rv, fv, wr, werr;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  ping_pong_line_buffer_if #(.address_width(AW), .data_width(DW)) bus_if ();

  ping_pong_line_buffer #(
    .address_width(AW),
    .data_width   (DW),
    .line_length  (LL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset                = v.rst_n[0];
    bus_if.write_enable  = v.we[0];
    bus_if.write_address = AW'(v.wa);
    bus_if.write_data    = DW'(v.wd);
    bus_if.write_commit  = v.wc[0];
    bus_if.read_enable   = v.re[0];
    bus_if.read_address  = AW'(v.ra);
    bus_if.read_release  = v.rel[0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input string tag, input vec_t v);
    drive(v);
    tick();
    check({tag, "_rdata"}, {8'h0, bus_if.read_data}, 32'(v.rd));
    check({tag, "_rvalid"}, {31'h0, bus_if.read_valid}, 32'(v.rv));
    check({tag, "_fvalid"}, {31'h0, bus_if.front_valid}, 32'(v.fv));
    check({tag, "_wready"}, {31'h0, bus_if.write_ready}, 32'(v.wr));
    check({tag, "_werror"}, {31'h0, bus_if.write_error}, 32'(v.werr));
    $display("vec %s: rd=0x%06h rv=%0d fv=%0d wr=%0d werr=%0d", tag, bus_if.read_data,
             bus_if.read_valid, bus_if.front_valid, bus_if.write_ready, bus_if.write_error);
  endtask

  vec_t tbl_a[5];
  vec_t tbl_b[19];

  initial begin
    //              rst we wa   wd        wc re ra  rel   rd        rv fv wr werr
    tbl_a[0]  = '{1, 0, 0,  0,        0, 1, 5,  0,  'h000105, 1, 1, 1, 0};
    tbl_a[1]  = '{1, 0, 0,  0,        0, 1, 63, 0,  'h00013F, 1, 1, 1, 0};
    tbl_a[2]  = '{1, 0, 0,  0,        0, 0, 0,  0,  'h00013F, 0, 1, 1, 0};
    tbl_a[3]  = '{1, 0, 0,  0,        0, 1, 64, 0,  0,        0, 1, 1, 0};
    tbl_a[4]  = '{1, 0, 0,  0,        0, 1, 0,  1,  'h000100, 1, 1, 1, 0};

    tbl_b[0]  = '{1, 0, 0,  0,        0, 1, 9,  0,  'h000109, 1, 1, 0, 0};
    tbl_b[1]  = '{1, 1, 3,  'h123456, 0, 0, 0,  0,  'h000109, 0, 1, 0, 1};
    tbl_b[2]  = '{1, 1, 64, 'h654321, 0, 0, 0,  0,  'h000109, 0, 1, 0, 1};
    tbl_b[3]  = '{1, 0, 0,  0,        1, 0, 0,  0,  'h000109, 0, 1, 0, 1};
    tbl_b[4]  = '{1, 0, 0,  0,        0, 1, 7,  1,  'h000107, 1, 1, 1, 1};
    tbl_b[5]  = '{1, 0, 0,  0,        0, 1, 7,  0,  'hAAAAAA, 1, 1, 1, 1};
    tbl_b[6]  = '{1, 0, 0,  0,        0, 1, 3,  0,  'hAAAAAA, 1, 1, 1, 1};
    tbl_b[7]  = '{1, 1, 2,  'h222222, 1, 1, 2,  1,  'hAAAAAA, 1, 1, 0, 1};
    tbl_b[8]  = '{1, 0, 0,  0,        0, 1, 2,  0,  'hAAAAAA, 1, 1, 0, 1};
    tbl_b[9]  = '{1, 0, 0,  0,        0, 1, 2,  1,  'hAAAAAA, 1, 1, 1, 1};
    tbl_b[10] = '{1, 0, 0,  0,        0, 1, 2,  0,  'h222222, 1, 1, 1, 1};
    tbl_b[11] = '{1, 0, 0,  0,        0, 1, 1,  0,  'h000101, 1, 1, 1, 1};
    tbl_b[12] = '{1, 1, 0,  'h000005, 1, 1, 1,  0,  'h000101, 1, 1, 0, 1};
    tbl_b[13] = '{0, 0, 0,  0,        0, 1, 1,  0,  0,        0, 0, 1, 0};
    tbl_b[14] = '{1, 0, 0,  0,        0, 1, 1,  0,  0,        0, 0, 1, 0};
    tbl_b[15] = '{1, 1, 64, 'h777777, 0, 0, 0,  0,  0,        0, 0, 1, 1};
    tbl_b[16] = '{1, 1, 4,  'h444444, 1, 0, 0,  0,  0,        0, 1, 1, 1};
    tbl_b[17] = '{1, 0, 0,  0,        0, 1, 4,  0,  'h444444, 1, 1, 1, 1};
    tbl_b[18] = '{1, 0, 0,  0,        0, 1, 5,  0,  'h000105, 1, 1, 1, 1};

    // Reset, then read while no line is committed.
    apply("rst", '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0});
    apply("rd_empty", '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0});

    // Fill the first line. The last write carries the commit, which swaps at once.
    for (int i = 0; i < LL; i++) begin
      drive('{1, 1, i, 'h000100 + i, (i == LL - 1) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0});
      tick();
      check($sformatf("fill%0d_wready", i), {31'h0, bus_if.write_ready}, 32'd1);
      check($sformatf("fill%0d_fvalid", i), {31'h0, bus_if.front_valid}, (i == LL - 1) ? 32'd1 : 32'd0);
    end
    $display("fill line 1 done: fv=%0d wr=%0d", bus_if.front_valid, bus_if.write_ready);

    for (int i = 0; i < 5; i++) apply($sformatf("a%0d", i), tbl_a[i]);

    // Write the second line while scanning the first. Neither side stalls the other.
    for (int i = 0; i < LL; i++) begin
      drive('{1, 1, i, 'hAAAAAA, 0, 1, i, 0, 0, 0, 0, 0, 0});
      tick();
      check($sformatf("scan%0d_rdata", i), {8'h0, bus_if.read_data}, 32'h100 + 32'(i));
      check($sformatf("scan%0d_rvalid", i), {31'h0, bus_if.read_valid}, 32'd1);
    end
    $display("fill line 2 done: last rd=0x%06h", bus_if.read_data);
    apply("commit2", '{1, 0, 0, 0, 1, 0, 0, 0, 'h00013F, 0, 1, 0, 0});

    for (int i = 0; i < 19; i++) apply($sformatf("b%0d", i), tbl_b[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
